uart_receiver: RTL and testbench

Receive half of the console serial port: deserialises 8N1 frames arriving on `rx` and buffers them in a FIFO. It exposes the buffered bytes to the 65C02 as a two-register bus responder selected by the address decoder's IO chip select. An interrupt is raised while data is waiting. The block runs entirely in the CPU clock domain, deriving bit timing from a clock-per-bit divider.

---
 rtl/uart_receiver.sv | 209 ++++++++++++++++++++
 tb/tb_uart_receiver.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// Console UART receive path: 8N1 deserialiser, receive FIFO and a
// two-register 65C02 bus responder with a level interrupt.
module uart_receiver #(
  parameter int BIT_CLOCKS = 43,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] address,
  input  logic        write_enable,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        irq,
  input  logic        rx
);

  localparam int CW = $clog2(BIT_CLOCKS);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] C_FULL = CW'(BIT_CLOCKS - 1);
  localparam logic [CW-1:0] C_HALF = CW'(BIT_CLOCKS / 2 - 1);
  localparam logic [PW:0]   C_DEPTH = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          r_rx_meta;
  logic          r_rx_s;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  logic          r_ovr;
  logic          r_fe;
  logic          r_irq_en;
  logic [7:0]    r_data_out;

  logic          w_cnt_zero;
  logic          w_stop_smp;
  logic          w_push;
  logic          w_fe_set;
  logic          w_empty;
  logic          w_full;
  logic          w_rd;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_ovr_set;
  logic          w_ctrl_wr;
  logic          w_clr;
  logic          w_irq;
  logic [7:0]    w_status;
  logic [7:0]    w_head;
  logic          w_unused_bits;

  assign w_unused_bits = ^{address[15:1], data_in[7:2]};

  assign w_cnt_zero = (r_cnt == '0);
  assign w_stop_smp = (r_state == S_STOP) && w_cnt_zero;
  assign w_push     = w_stop_smp && r_rx_s;
  assign w_fe_set   = w_stop_smp && !r_rx_s;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_DEPTH);
  assign w_rd      = enable && !write_enable;
  assign w_pop     = w_rd && !address[0] && !w_empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_ovr_set = w_push && w_full && !w_pop;
  assign w_ctrl_wr = enable && write_enable && address[0];
  assign w_clr     = w_ctrl_wr && data_in[1];

  assign w_irq    = r_irq_en && !w_empty;
  assign w_status = {w_irq, 3'b000, r_fe, r_ovr, w_full, !w_empty};
  assign w_head   = w_empty ? 8'h00 : r_mem[r_rd_ptr];

  assign irq      = w_irq;
  assign data_out = r_data_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_cnt   <= C_HALF;
          end
        end
        S_START: begin
          if (w_cnt_zero) begin
            if (!r_rx_s) begin
              r_state <= S_DATA;
              r_cnt   <= C_FULL;
              r_idx   <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (w_cnt_zero) begin
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_cnt   <= C_FULL;
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (w_cnt_zero) begin
            r_state <= r_rx_s ? S_IDLE : S_BREAK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_BREAK: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flags: a set landing with a clear wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovr      <= 1'b0;
      r_fe       <= 1'b0;
      r_irq_en   <= 1'b0;
      r_data_out <= 8'h00;
    end else begin
      if (w_ovr_set) begin
        r_ovr <= 1'b1;
      end else if (w_clr) begin
        r_ovr <= 1'b0;
      end
      if (w_fe_set) begin
        r_fe <= 1'b1;
      end else if (w_clr) begin
        r_fe <= 1'b0;
      end
      if (w_ctrl_wr) begin
        r_irq_en <= data_in[0];
      end
      if (w_rd) begin
        r_data_out <= address[0] ? w_status : w_head;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomised bench for uart_receiver against a queue-based model
// of the receive FIFO, sticky flags and register map.
module tb_uart_receiver;

  localparam int BC    = 8;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] address;
  logic        write_enable;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        irq;
  logic        rx;

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];
  logic       m_ovr;
  logic       m_fe;
  logic       m_irqen;

  uart_receiver #(
    .BIT_CLOCKS(BC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .address(address),
    .write_enable(write_enable),
    .data_in(data_in),
    .data_out(data_out),
    .irq(irq),
    .rx(rx)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] m_status();
    logic ne;
    ne = (mq.size() != 0);
    return {m_irqen && ne, 3'b000, m_fe, m_ovr, mq.size() == DEPTH, ne};
  endfunction

  function automatic logic [7:0] m_pop();
    if (mq.size() == 0) return 8'h00;
    return mq.pop_front();
  endfunction

  task automatic m_clear();
    mq.delete();
    m_ovr   = 1'b0;
    m_fe    = 1'b0;
    m_irqen = 1'b0;
  endtask

  task automatic bus_read(input logic a, output logic [7:0] d);
    logic [15:0] a16;
    a16          = 16'($urandom);
    a16[0]       = a;
    address      = a16;
    write_enable = 1'b0;
    enable       = 1'b1;
    cyc(1);
    enable = 1'b0;
    d      = data_out;
  endtask

  task automatic bus_write(input logic a, input logic [7:0] d);
    logic [15:0] a16;
    a16          = 16'($urandom);
    a16[0]       = a;
    address      = a16;
    data_in      = d;
    write_enable = 1'b1;
    enable       = 1'b1;
    cyc(1);
    enable       = 1'b0;
    write_enable = 1'b0;
    if (a) begin
      m_irqen = d[0];
      if (d[1]) begin
        m_ovr = 1'b0;
        m_fe  = 1'b0;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic sv,
                            input int stop_cyc);
    rx = 1'b0;
    cyc(BC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(BC);
    end
    rx = sv;
    cyc(stop_cyc);
    rx = 1'b1;
    if (sv) begin
      if (mq.size() == DEPTH) m_ovr = 1'b1;
      else mq.push_back(b);
    end else begin
      m_fe = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset        = 1'b0;
    rx           = 1'b1;
    enable       = 1'b0;
    write_enable = 1'b0;
    address      = '0;
    data_in      = '0;
    m_clear();
    cyc(3);
    checks++;
    if (data_out !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: data_out=%h irq=%b want 00/0", data_out, irq);
    end
    reset = 1'b1;
    cyc(2);
    bus_read(1'b1, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL reset_status: got %h want 00", d);
    end
    bus_read(1'b0, d);
    checks++;
    if (d !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: got %h irq=%b want 00/0", d, irq);
    end
  endtask

  task automatic test_latency();
    logic [7:0] d;
    logic [7:0] e;
    logic [9:0] fb;
    bus_write(1'b1, 8'h01);
    fb = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10 * BC; k++) begin
      rx = fb[k / BC];
      cyc(1);
      if (k + 1 == 78) begin
        checks++;
        if (irq !== 1'b0) begin
          errors++;
          $display("FAIL latency_early: irq=%b want 0 at edge 78", irq);
        end
      end
      if (k + 1 == 79) begin
        checks++;
        if (irq !== 1'b1) begin
          errors++;
          $display("FAIL latency_edge: irq=%b want 1 at edge 79", irq);
        end
      end
    end
    rx = 1'b1;
    mq.push_back(8'hA5);
    bus_write(1'b1, 8'h00);
    bus_read(1'b0, d);
    e = m_pop();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL latency_data: got %h want %h", d, e);
    end
    bus_read(1'b1, d);
    e = m_status();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL latency_status: got %h want %h", d, e);
    end
  endtask

  task automatic test_irq();
    logic [7:0] d;
    logic [7:0] e;
    bus_write(1'b1, 8'h01);
    send_frame(8'h3C, 1'b1, BC);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise: irq=%b want 1", irq);
    end
    send_frame(8'hC3, 1'b1, BC);
    bus_read(1'b0, d);
    e = m_pop();
    checks++;
    if (d !== e || irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_read1: got %h irq=%b want %h/1", d, irq, e);
    end
    bus_read(1'b0, d);
    e = m_pop();
    checks++;
    if (d !== e || irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_read2: got %h irq=%b want %h/0", d, irq, e);
    end
    bus_write(1'b1, 8'h00);
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    logic [7:0] e;
    for (int i = 0; i < DEPTH + 1; i++) begin
      send_frame(8'($urandom), 1'b1, BC);
    end
    bus_read(1'b1, d);
    e = m_status();
    checks++;
    if (d !== e || d !== 8'h07) begin
      errors++;
      $display("FAIL ovr_status: got %h want %h (07)", d, e);
    end
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(1'b0, d);
      e = m_pop();
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL ovr_data%0d: got %h want %h", i, d, e);
      end
    end
    bus_read(1'b0, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL empty_read: got %h want 00", d);
    end
    bus_read(1'b1, d);
    e = m_status();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL ovr_sticky: got %h want %h", d, e);
    end
    bus_write(1'b1, 8'h02);
    bus_read(1'b1, d);
    e = m_status();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL ovr_clear: got %h want %h", d, e);
    end
  endtask

  task automatic test_framing();
    logic [7:0] d;
    logic [7:0] e;
    send_frame(8'($urandom), 1'b0, 3 * BC);
    cyc(4);
    bus_read(1'b1, d);
    e = m_status();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL fe_status: got %h want %h", d, e);
    end
    send_frame(8'h55, 1'b1, BC);
    bus_read(1'b1, d);
    e = m_status();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL fe_next_status: got %h want %h", d, e);
    end
    bus_read(1'b0, d);
    e = m_pop();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL fe_next_data: got %h want %h", d, e);
    end
    bus_write(1'b1, 8'h02);
    bus_read(1'b1, d);
    e = m_status();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL fe_clear: got %h want %h", d, e);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    logic [7:0] e;
    rx = 1'b0;
    cyc(BC / 4);
    rx = 1'b1;
    cyc(2 * BC);
    bus_read(1'b1, d);
    e = m_status();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL glitch_status: got %h want %h", d, e);
    end
    send_frame(8'($urandom), 1'b1, BC);
    bus_read(1'b0, d);
    e = m_pop();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL glitch_next: got %h want %h", d, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [7:0] e;
    int n;
    for (int i = 0; i < 5; i++) begin
      send_frame(8'($urandom), 1'b1, BC / 2 + 1);
    end
    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(BC / 2 + 1, 2 * BC);
      send_frame(8'($urandom), 1'b1, n);
      cyc($urandom_range(0, 6));
    end
    bus_read(1'b1, d);
    e = m_status();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL b2b_status: got %h want %h", d, e);
    end
    for (int i = 0; i < 11; i++) begin
      bus_read(1'b0, d);
      e = m_pop();
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL b2b_data%0d: got %h want %h", i, d, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic [7:0] e;
    bus_write(1'b1, 8'h01);
    send_frame(8'($urandom), 1'b1, BC);
    bus_read(1'b1, d);
    e = m_status();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL pre_reset_status: got %h want %h", d, e);
    end
    rx = 1'b0;
    cyc(BC);
    rx = 1'b1;
    cyc(2 * BC);
    reset = 1'b0;
    m_clear();
    #1;
    checks++;
    if (data_out !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_out: data_out=%h irq=%b want 00/0",
               data_out, irq);
    end
    cyc(2);
    reset = 1'b1;
    cyc(12 * BC);
    bus_read(1'b1, d);
    e = m_status();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL post_reset_status: got %h want %h", d, e);
    end
    bus_read(1'b0, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_data: got %h want 00", d);
    end
    send_frame(8'($urandom), 1'b1, BC);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_irqen: irq=%b want 0", irq);
    end
    bus_read(1'b0, d);
    e = m_pop();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL post_reset_rx: got %h want %h", d, e);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_irq();
    test_overrun();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
